// File: rtl/divider_8bit_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Results register on entry to DONE and hold until the next accepted start.
module divider_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH:0]   r, r_sh, t, r_nxt;
  logic [WIDTH-1:0] q, q_nxt, b_r;
  logic [CW-1:0]    cnt;

  // One restoring step: shift in next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    t     = r_sh - {1'b0, b_r};
    r_nxt = t[WIDTH] ? r_sh : t;
    q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      b_r         <= '0;
      cnt         <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r   <= '0;
          q   <= A;
          b_r <= B;
          cnt <= '0;
          if (B == '0) begin
            Quotient    <= '1;
            Remainder   <= A;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Quotient    <= q_nxt;
            Remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Directed checks for divider_8bit_seq: arithmetic, latency, divide-by-zero,
// start-while-busy, mid-operation reset, plus a spread of model-checked pairs.
module tb_divider_8bit_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] A, B;
  logic [7:0] Quotient, Remainder;
  logic       busy, done, div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divider_8bit_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then count edges until done (bounded).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int lat;
    run_op(a, b, lat);
    chk({tag, "_lat"}, lat, (b == 8'd0) ? 1 : 9);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dz"}, div_by_zero, ez);
  endtask

  initial begin
    int lat;
    int n_done;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;

    // Basic vectors
    check_op("t1_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    check_op("t2_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    check_op("t2_5_10", 8'd5, 8'd10, 8'd0, 8'd5, 1'b0);
    check_op("t2_0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);

    // Divide by zero: busy only for the DONE cycle, flag held into IDLE
    check_op("t3_77_0", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);
    chk("t3_busy_in_done", busy, 1);
    @(posedge clk); #1;
    chk("t3_busy_after", busy, 0);
    chk("t3_dz_held", div_by_zero, 1);
    chk("t3_q_held", Quotient, 8'hFF);

    // start held high, operands changed mid-CALC
    A = 8'd100; B = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy_calc", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    A = 8'd50; B = 8'd3;
    chk("t4_q_stable_calc", Quotient, 8'hFF);
    chk("t4_dz_stable_calc", div_by_zero, 1);
    lat = 4;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t4_lat", lat, 9);
    chk("t4_q", Quotient, 8'd11);
    chk("t4_r", Remainder, 8'd1);
    chk("t4_dz", div_by_zero, 0);
    @(posedge clk); #1;
    chk("t4_gap_busy", busy, 0);
    chk("t4_gap_done", done, 0);
    @(posedge clk); #1;
    chk("t4_restart_busy", busy, 1);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t4b_lat", lat, 9);
    chk("t4b_q", Quotient, 8'd16);
    chk("t4b_r", Remainder, 8'd2);

    // Reset during the 4th CALC cycle discards the operation
    @(posedge clk); #1;
    A = 8'd200; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_q", Quotient, 0);
    chk("t5_r", Remainder, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_dz", div_by_zero, 0);
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    chk("t5_no_done", n_done, 0);
    check_op("t5_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

    // Corner pairs and a spread of random pairs against a reference model
    check_op("c_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    check_op("c_254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
    check_op("c_128_2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0);
    check_op("c_0_0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);
    check_op("c_255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      check_op("rnd", ra, rb,
               (rb == 8'd0) ? 8'hFF : ra / rb,
               (rb == 8'd0) ? ra : ra % rb,
               rb == 8'd0);
      if (rb != 8'd0) chk("rnd_identity", 32'(Quotient) * 32'(rb) + 32'(Remainder), 32'(ra));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
